plane_mixer: RTL
================

Name: plane_mixer

Overview:
Final compositing stage directly downstream of the foreground plane and background plane. Per pixel, it selects or blends the 24-bit foreground pixel over the background pixel using a colour-key transparency test. It applies a frame-synchronous global fade (brightness ramp) and delays the timing-generator sync signals so that they stay aligned with the 3-cycle pixel pipeline. Its output drives the video encoder / TMDS stage.

Parameters:
FADE_STEP_FRAMES, 2, number of VS rising edges per fade level step (legal range 1..255)

Ports:
I_pxl_clk  in  1  pixel clock
I_rst_n  in  1  asynchronous reset, active-low
I_de  in  1  data enable from timing generator, active-high
I_hs  in  1  horizontal sync, active-high
I_vs  in  1  vertical sync, active-high
I_fg_pixel  in  24  foreground pixel {R[23:16],G[15:8],B[7:0]}
I_bg_pixel  in  24  background pixel, same packing
I_key_en  in  1  enables colour-key transparency
I_key_color  in  24  transparent colour key
I_blend_en  in  1  50% blend of non-keyed foreground with background
I_fade_out  in  1  single-cycle request: ramp to black
I_fade_in  in  1  single-cycle request: ramp to full brightness
O_de  out  1  I_de delayed 3 cycles
O_hs  out  1  I_hs delayed 3 cycles
O_vs  out  1  I_vs delayed 3 cycles
O_pixel  out  24  composited pixel
O_fade_level  out  5  current brightness level, 0..16
O_fade_busy  out  1  high while fading

Behaviour:
- Clocking and reset: I_pxl_clk clocks all logic. Reset I_rst_n is asynchronous, active-low.
- Reset values: O_pixel=0, O_de=O_hs=O_vs=0, O_fade_level=16, O_fade_busy=0, FSM=ON, frame counter=0, all pipeline registers 0.
- Pipeline latency is fixed at 3 cycles from inputs to O_pixel/O_de/O_hs/O_vs. Syncs pass through a 3-deep shift register. The bench can rely on this latency.
- Stage 1 (select):
  - key_hit = I_key_en && (I_fg_pixel == I_key_color), full 24-bit compare.
  - key_hit: sel = I_bg_pixel.
  - else if I_blend_en: sel per channel = (fg_c + bg_c) >> 1, with a 9-bit sum truncated to 8 bits.
  - else: sel = I_fg_pixel.
- Stage 2 (fade): per channel prod = sel_c * level, 8b x 5b -> 13b. The level used is the O_fade_level value present in that cycle.
- Stage 3 (output): chan = prod[11:4]. Level 16 returns sel_c exactly; level 0 returns 0. No overflow is possible (255*16>>4 = 255). If the delayed DE is 0, O_pixel = 24'h000000 (blanking).
- VS edge detect: vs_rise = I_vs && !vs_prev, with vs_prev registered.
- Fade step timing: the frame counter increments on each vs_rise while busy. When it reaches FADE_STEP_FRAMES on a vs_rise, the counter clears to 0 and the level steps by 1. Level only changes on a vs_rise cycle, so there is no mid-frame tearing.
- FSM states and transitions:
  - ON (level 16, busy 0):
    - I_fade_out -> FADING_OUT, counter cleared.
    - I_fade_in ignored.
  - FADING_OUT (busy 1):
    - Level decrements at each step.
    - Level reaches 0 -> OFF.
    - I_fade_in -> FADING_IN (reversal from the current level, counter cleared).
  - OFF (level 0, busy 0):
    - I_fade_in -> FADING_IN, counter cleared.
    - I_fade_out ignored.
  - FADING_IN (busy 1):
    - Level increments at each step.
    - Level reaches 16 -> ON.
    - I_fade_out -> FADING_OUT (reversal, counter cleared).
- Boundary conditions:
  - I_fade_in and I_fade_out both high in the same cycle: both ignored, no state change.
  - A request arriving in the same cycle as a step vs_rise: the request takes priority and the step is not applied in that cycle.
  - Level is clamped to 0..16 and never wraps.
  - Reset mid-fade: immediate return to ON/level 16, pipeline flushed to 0.
  - Requests are edge-insensitive. A request held high for several cycles acts like a repeated request; in ON/OFF, the redundant direction is ignored.

Test Plan:
1. Reset and latency: hold reset, release, drive I_de=1, fg=24'h3F5F7F, key_en=0, blend_en=0 -> O_pixel=24'h3F5F7F exactly 3 cycles later. O_de/O_hs/O_vs equal the inputs delayed 3 cycles. Fade_level=16, busy=0.
2. Colour key: key_en=1, key=24'h3F5F7F, fg=24'h3F5F7F, bg=24'h102030 -> O_pixel=24'h102030. Change fg to 24'h3F5F7E -> O_pixel=24'h3F5F7E.
3. Blend: blend_en=1, fg=24'hFF0080, bg=24'h01FF81 -> O_pixel=24'h807F80. With DE=0 at the input -> O_pixel=0 three cycles later.
4. Fade out, FADE_STEP_FRAMES=2: pulse fade_out, then 32 VS pulses.
   - busy=1, level drops by 1 every 2nd vs_rise: 16, 15, ... 0.
   - After the 32nd rise: state OFF, busy=0.
   - At level 8, fg=24'hFF8040 -> O_pixel=24'h7F4020.
5. Reversal: after fade_out and 6 VS rises (level 13), pulse fade_in -> busy stays 1. Level reaches 14 on the 2nd subsequent rise and 16 after 6 rises; state ON, busy=0.
6. Simultaneous requests and reset: fade_in and fade_out high in the same cycle in ON -> no change. Start fade_out, assert reset mid-fade -> level=16, busy=0, O_pixel=0 immediately.

Source files
------------

// File: rtl/plane_mixer.sv
// plane_mixer: colour-key/blend compositing of foreground over background with frame-synchronous fade,
// 3-cycle pixel pipeline with matching sync delay.
module plane_mixer #(
  parameter int FADE_STEP_FRAMES = 2
) (
  input  logic        I_pxl_clk,
  input  logic        I_rst_n,
  input  logic        I_de,
  input  logic        I_hs,
  input  logic        I_vs,
  input  logic [23:0] I_fg_pixel,
  input  logic [23:0] I_bg_pixel,
  input  logic        I_key_en,
  input  logic [23:0] I_key_color,
  input  logic        I_blend_en,
  input  logic        I_fade_out,
  input  logic        I_fade_in,
  output logic        O_de,
  output logic        O_hs,
  output logic        O_vs,
  output logic [23:0] O_pixel,
  output logic [4:0]  O_fade_level,
  output logic        O_fade_busy
);
  localparam logic [7:0] STEP = 8'(FADE_STEP_FRAMES);
  typedef enum logic [1:0] {ON, FADING_OUT, OFF, FADING_IN} state_t;
  state_t state, state_n;
  logic [4:0] level, level_n;
  logic [7:0] cnt, cnt_n, cnt_inc;
  logic vs_prev, vs_rise, step, req_in, req_out, key_hit;
  logic [23:0] blend, sel, sel_s1, mixed;
  logic [38:0] prod, prod_s2;
  logic [2:0] sync1, sync2, sync3;

  assign key_hit = I_key_en && (I_fg_pixel == I_key_color);
  for (genvar i = 0; i < 3; i++) begin : g_ch
    logic [8:0] sum;
    assign sum = {1'b0, I_fg_pixel[8*i +: 8]} + {1'b0, I_bg_pixel[8*i +: 8]};
    assign blend[8*i +: 8] = sum[8:1];
    assign prod[13*i +: 13] = 13'(sel_s1[8*i +: 8]) * 13'(level);
    assign mixed[8*i +: 8] = prod_s2[13*i + 4 +: 8];
  end
  assign sel = key_hit ? I_bg_pixel : I_blend_en ? blend : I_fg_pixel;

  assign vs_rise = I_vs && !vs_prev;
  assign req_in  = I_fade_in && !I_fade_out;
  assign req_out = I_fade_out && !I_fade_in;
  assign cnt_inc = cnt + 8'd1;
  assign step    = vs_rise && (cnt_inc == STEP);

  // A request always wins over a step landing in the same cycle.
  always_comb begin
    state_n = state;
    level_n = level;
    cnt_n   = cnt;
    case (state)
      ON:  if (req_out) begin state_n = FADING_OUT; cnt_n = '0; end
      OFF: if (req_in) begin state_n = FADING_IN; cnt_n = '0; end
      FADING_OUT:
        if (req_in) begin
          state_n = FADING_IN;
          cnt_n   = '0;
        end else if (vs_rise) begin
          cnt_n = step ? 8'd0 : cnt_inc;
          if (step) begin
            level_n = (level > 5'd1) ? level - 5'd1 : 5'd0;
            state_n = (level > 5'd1) ? FADING_OUT : OFF;
          end
        end
      FADING_IN:
        if (req_out) begin
          state_n = FADING_OUT;
          cnt_n   = '0;
        end else if (vs_rise) begin
          cnt_n = step ? 8'd0 : cnt_inc;
          if (step) begin
            level_n = (level < 5'd15) ? level + 5'd1 : 5'd16;
            state_n = (level < 5'd15) ? FADING_IN : ON;
          end
        end
      default: state_n = ON;
    endcase
  end

  always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state   <= ON;
      level   <= 5'd16;
      cnt     <= '0;
      vs_prev <= 1'b0;
      sel_s1  <= '0;
      prod_s2 <= '0;
      sync1   <= '0;
      sync2   <= '0;
      sync3   <= '0;
      O_pixel <= '0;
    end else begin
      state   <= state_n;
      level   <= level_n;
      cnt     <= cnt_n;
      vs_prev <= I_vs;
      sel_s1  <= sel;
      prod_s2 <= prod;
      sync1   <= {I_de, I_hs, I_vs};
      sync2   <= sync1;
      sync3   <= sync2;
      O_pixel <= sync2[2] ? mixed : 24'h000000;
    end
  end

  assign {O_de, O_hs, O_vs} = sync3;
  assign O_fade_level = level;
  assign O_fade_busy  = (state == FADING_OUT) || (state == FADING_IN);
endmodule
